// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder.
// Accepts an abstract instruction request (class plus register and immediate
// fields) and assembles the 32-bit MIPS word. The Op and Funct fields are
// placed exactly where the single-cycle control decoder reads them.
// Each legal word is tagged with a running PC and queued in a 2-entry skid
// buffer with registered outputs. Illegal classes are accepted and dropped.
// Illegal classes are also counted, and each one raises a one-cycle pulse.
module mips_instr_encoder #(
    parameter logic [31:0] PC_RESET = 32'h0040_0000,
    parameter int          CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_class,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [15:0]      in_imm,
    input  logic [25:0]      in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic             illegal_pulse,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Request classes
    localparam logic [3:0] CLS_ADD  = 4'd0;
    localparam logic [3:0] CLS_SUB  = 4'd1;
    localparam logic [3:0] CLS_AND  = 4'd2;
    localparam logic [3:0] CLS_OR   = 4'd3;
    localparam logic [3:0] CLS_SLT  = 4'd4;
    localparam logic [3:0] CLS_LW   = 4'd5;
    localparam logic [3:0] CLS_SW   = 4'd6;
    localparam logic [3:0] CLS_BEQ  = 4'd7;
    localparam logic [3:0] CLS_ADDI = 4'd8;
    localparam logic [3:0] CLS_J    = 4'd9;

    // Opcodes and R-type function codes expected by the decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Buffer state: head is what the consumer sees; tail only holds a word
    // while the buffer is full.
    logic [1:0]       count_reg, count_next;
    logic [31:0]      head_instr_reg, head_instr_next;
    logic [31:0]      head_pc_reg, head_pc_next;
    logic [31:0]      tail_instr_reg, tail_instr_next;
    logic [31:0]      tail_pc_reg, tail_pc_next;
    logic [31:0]      pc_reg, pc_next;
    logic             illegal_pulse_reg, illegal_pulse_next;
    logic [CNT_W-1:0] illegal_cnt_reg, illegal_cnt_next;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        push;
    logic        pop;
    logic        illegal_accept;

    // Assemble the instruction word for the requested class
    always_comb begin
        enc_word  = 32'h0000_0000;
        enc_legal = 1'b1;
        case (in_class)
            CLS_ADD:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b00000, FN_ADD};
            CLS_SUB:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b00000, FN_SUB};
            CLS_AND:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b00000, FN_AND};
            CLS_OR:   enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b00000, FN_OR};
            CLS_SLT:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b00000, FN_SLT};
            CLS_LW:   enc_word = {OP_LW,   in_rs, in_rt, in_imm};
            CLS_SW:   enc_word = {OP_SW,   in_rs, in_rt, in_imm};
            CLS_BEQ:  enc_word = {OP_BEQ,  in_rs, in_rt, in_imm};
            CLS_ADDI: enc_word = {OP_ADDI, in_rs, in_rt, in_imm};
            CLS_J:    enc_word = {OP_J, in_target};
            default:  enc_legal = 1'b0;
        endcase
    end

    // Handshake decode; in_ready comes from buffer occupancy alone
    always_comb begin
        in_ready       = (count_reg != 2'd2);
        accept         = in_valid & in_ready;
        push           = accept & enc_legal;
        illegal_accept = accept & ~enc_legal;
        pop            = out_ready & (count_reg != 2'd0);
    end

    // Next buffer contents; a push with count 2 cannot occur since in_ready is low
    always_comb begin
        count_next      = count_reg;
        head_instr_next = head_instr_reg;
        head_pc_next    = head_pc_reg;
        tail_instr_next = tail_instr_reg;
        tail_pc_next    = tail_pc_reg;
        case (count_reg)
            2'd0: begin
                if (push) begin
                    head_instr_next = enc_word;
                    head_pc_next    = pc_reg;
                    count_next      = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_instr_next = enc_word;
                    head_pc_next    = pc_reg;
                end else if (push) begin
                    tail_instr_next = enc_word;
                    tail_pc_next    = pc_reg;
                    count_next      = 2'd2;
                end else if (pop) begin
                    count_next      = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_instr_next = tail_instr_reg;
                    head_pc_next    = tail_pc_reg;
                    count_next      = 2'd1;
                end
            end
        endcase
    end

    // PC tag advances only for words that enter the buffer
    always_comb begin
        pc_next = push ? (pc_reg + 32'd4) : pc_reg;
    end

    // Illegal-request pulse and saturating counter
    always_comb begin
        illegal_pulse_next = illegal_accept;
        illegal_cnt_next   = illegal_cnt_reg;
        if (illegal_accept && !(&illegal_cnt_reg)) begin
            illegal_cnt_next = illegal_cnt_reg + CNT_ONE;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg         <= 2'd0;
            head_instr_reg    <= 32'h0000_0000;
            head_pc_reg       <= 32'h0000_0000;
            tail_instr_reg    <= 32'h0000_0000;
            tail_pc_reg       <= 32'h0000_0000;
            pc_reg            <= PC_RESET;
            illegal_pulse_reg <= 1'b0;
            illegal_cnt_reg   <= '0;
        end else begin
            count_reg         <= count_next;
            head_instr_reg    <= head_instr_next;
            head_pc_reg       <= head_pc_next;
            tail_instr_reg    <= tail_instr_next;
            tail_pc_reg       <= tail_pc_next;
            pc_reg            <= pc_next;
            illegal_pulse_reg <= illegal_pulse_next;
            illegal_cnt_reg   <= illegal_cnt_next;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        out_valid     = (count_reg != 2'd0);
        out_instr     = head_instr_reg;
        out_pc        = head_pc_reg;
        illegal_pulse = illegal_pulse_reg;
        illegal_cnt   = illegal_cnt_reg;
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Testbench for mips_instr_encoder.
// Stimulus comes from a table of known encodings, a few hand-written
// sequences and random traffic. Expected values come from a queue-based
// reference model.
module tb_mips_instr_encoder;

    localparam int          CNT_W    = 8;
    localparam logic [31:0] PC_RESET = 32'h0040_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_class;
    logic [4:0]       in_rs;
    logic [4:0]       in_rt;
    logic [4:0]       in_rd;
    logic [15:0]      in_imm;
    logic [25:0]      in_target;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [31:0]      out_pc;
    logic             illegal_pulse;
    logic [CNT_W-1:0] illegal_cnt;

    mips_instr_encoder #(.PC_RESET(PC_RESET), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .illegal_pulse(illegal_pulse), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];
    logic [31:0] m_pc;
    int          m_cnt;
    bit          m_pulse;

    typedef struct {
        int          cls;
        int          rs;
        int          rt;
        int          rd;
        int          imm;
        int          tgt;
        logic [31:0] exp;
    } vec_t;

    // Field packing by arithmetic from the instruction-format rules
    function automatic logic [31:0] ref_encode(int cls, int rs, int rt, int rd, int imm, int tgt);
        longint funct_tab[5] = '{32, 34, 36, 37, 42};
        longint op_tab[4]    = '{35, 43, 4, 8};
        longint w;
        if (cls < 5)
            w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + funct_tab[cls];
        else if (cls < 9)
            w = op_tab[cls-5] * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
        else
            w = 2 * 67108864 + longint'(tgt);
        return w[31:0];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_instr.delete();
        q_pc.delete();
        m_pc    = PC_RESET;
        m_cnt   = 0;
        m_pulse = 0;
    endtask

    task automatic check_state(string tag);
        check({tag, ".in_ready"}, {31'd0, in_ready}, (q_instr.size() < 2) ? 32'd1 : 32'd0);
        check({tag, ".out_valid"}, {31'd0, out_valid}, (q_instr.size() > 0) ? 32'd1 : 32'd0);
        if (q_instr.size() > 0) begin
            check({tag, ".out_instr"}, out_instr, q_instr[0]);
            check({tag, ".out_pc"}, out_pc, q_pc[0]);
        end
        check({tag, ".illegal_pulse"}, {31'd0, illegal_pulse}, {31'd0, m_pulse});
        check({tag, ".illegal_cnt"}, {24'd0, illegal_cnt}, m_cnt);
    endtask

    // Drive one request (called just after a falling edge), advance the model
    // across the rising edge, then compare at the next falling edge.
    task automatic cycle(input bit v, input int cls, input int rs, input int rt,
                         input int rd, input int imm, input int tgt, input bit ordy,
                         input string tag);
        bit acc;
        bit pop;
        in_valid  = v;
        in_class  = cls[3:0];
        in_rs     = rs[4:0];
        in_rt     = rt[4:0];
        in_rd     = rd[4:0];
        in_imm    = imm[15:0];
        in_target = tgt[25:0];
        out_ready = ordy;
        acc = v && (q_instr.size() < 2);
        pop = ordy && (q_instr.size() > 0);
        @(posedge clk);
        if (pop) begin
            void'(q_instr.pop_front());
            void'(q_pc.pop_front());
        end
        m_pulse = acc && (cls > 9);
        if (acc && cls <= 9) begin
            q_instr.push_back(ref_encode(cls, rs, rt, rd, imm, tgt));
            q_pc.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        if (acc && cls > 9 && m_cnt < 255) m_cnt++;
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic idle(input bit ordy, input string tag);
        cycle(1'b0, 0, 0, 0, 0, 0, 0, ordy, tag);
    endtask

    vec_t vecs[10];
    logic [31:0] held_instr;
    logic [31:0] held_pc;

    initial begin
        vecs[0] = '{0, 1, 2, 3, 16'h0000, 26'h3FFFFFF, 32'h0022_1820};
        vecs[1] = '{1, 1, 2, 3, 16'hFFFF, 26'h0000000, 32'h0022_1822};
        vecs[2] = '{2, 1, 2, 3, 16'h1234, 26'h1234567, 32'h0022_1824};
        vecs[3] = '{3, 1, 2, 3, 16'h0000, 26'h0000000, 32'h0022_1825};
        vecs[4] = '{4, 31, 31, 31, 16'h0000, 26'h0000000, 32'h03FF_F82A};
        vecs[5] = '{5, 29, 8, 31, 16'h0004, 26'h3FFFFFF, 32'h8FA8_0004};
        vecs[6] = '{6, 29, 8, 0, 16'hFFFC, 26'h0000000, 32'hAFA8_FFFC};
        vecs[7] = '{7, 4, 5, 7, 16'h0003, 26'h0000000, 32'h1085_0003};
        vecs[8] = '{8, 0, 9, 0, 16'h0010, 26'h0000000, 32'h2009_0010};
        vecs[9] = '{9, 31, 31, 31, 16'hFFFF, 26'h0100000, 32'h0810_0000};

        rst_n = 1'b0;
        in_valid = 1'b0; in_class = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
        in_imm = 16'd0; in_target = 26'd0; out_ready = 1'b0;
        model_reset();
        #3;
        check("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check("reset.out_pc", out_pc, 32'd0);
        check("reset.out_instr", out_instr, 32'd0);
        check("reset.illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
        check("reset.illegal_pulse", {31'd0, illegal_pulse}, 32'd0);
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-good encodings, streamed at one per cycle
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, vecs[i].cls, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm,
                  vecs[i].tgt, 1'b1, "table");
            check($sformatf("table[%0d].word", i), out_instr, vecs[i].exp);
            if (i == 0) check("table.first_pc", out_pc, 32'h0040_0000);
        end
        idle(1'b1, "drain");

        // Backpressure: two words fill the buffer, the third waits
        cycle(1'b1, 8, 0, 9, 0, 16'h0010, 0, 1'b0, "bp.addi");
        check("bp.addi.word", out_instr, 32'h2009_0010);
        held_instr = out_instr;
        held_pc    = out_pc;
        cycle(1'b1, 0, 4, 5, 6, 0, 0, 1'b0, "bp.add");
        check("bp.full.in_ready", {31'd0, in_ready}, 32'd0);
        cycle(1'b1, 1, 7, 8, 9, 0, 0, 1'b0, "bp.sub.blocked");
        cycle(1'b1, 1, 7, 8, 9, 0, 0, 1'b0, "bp.sub.blocked2");
        check("bp.hold.instr", out_instr, held_instr);
        check("bp.hold.pc", out_pc, held_pc);
        cycle(1'b1, 1, 7, 8, 9, 0, 0, 1'b1, "bp.release");
        cycle(1'b1, 1, 7, 8, 9, 0, 0, 1'b1, "bp.sub.accept");
        idle(1'b1, "bp.drain1");
        idle(1'b1, "bp.drain2");
        idle(1'b1, "bp.empty");

        // Illegal request then a jump: pc must not have moved
        held_pc = m_pc;
        cycle(1'b1, 15, 1, 2, 3, 16'h5555, 26'h2AAAAAA, 1'b1, "illegal");
        check("illegal.pulse", {31'd0, illegal_pulse}, 32'd1);
        cycle(1'b1, 9, 0, 0, 0, 0, 26'h0100000, 1'b1, "jump");
        check("jump.word", out_instr, 32'h0810_0000);
        check("jump.pc", out_pc, held_pc);
        check("jump.pulse_dropped", {31'd0, illegal_pulse}, 32'd0);
        idle(1'b1, "jump.drain");

        // Random mixed traffic
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
                  $urandom_range(0, 26'h3FFFFFF), $urandom_range(0, 2) != 0, "rand");
        end

        // Back-to-back illegal requests drive the counter into saturation
        for (int i = 0; i < 270; i++) begin
            cycle(1'b1, $urandom_range(10, 15), 0, 0, 0, 0, 0, 1'b1, "sat");
        end
        check("sat.cnt", {24'd0, illegal_cnt}, 32'd255);
        idle(1'b1, "sat.end");

        // Reset while the buffer is full
        cycle(1'b1, 0, 1, 1, 1, 0, 0, 1'b0, "pre_rst1");
        cycle(1'b1, 2, 2, 2, 2, 0, 0, 1'b0, "pre_rst2");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst.in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst.illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 0, 1, 2, 3, 0, 0, 1'b1, "postrst");
        check("postrst.pc", out_pc, 32'h0040_0000);
        check("postrst.word", out_instr, 32'h0022_1820);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
